// File: rtl/dcache_writeback_buffer_if.sv
// dcache_writeback_buffer_if: eviction, snoop and writeback-port signals of the dcache writeback buffer
interface dcache_writeback_buffer_if #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int LINE_BEATS = 8,
  parameter int DEPTH      = 4
);
  logic                          evict_valid;
  logic                          evict_ready;
  logic [ADDR_WIDTH-1:0]         evict_addr;
  logic [WIDTH*LINE_BEATS-1:0]   evict_data;
  logic [ADDR_WIDTH-1:0]         lookup_addr;
  logic                          lookup_hit;
  logic                          wb_reqcyc;
  logic [ADDR_WIDTH-1:0]         wb_req;
  logic [TAG_WIDTH-1:0]          wb_reqtag;
  logic [WIDTH-1:0]              wb_reqdata;
  logic                          wb_reqack;
  logic                          wb_writeack;
  logic [$clog2(DEPTH):0]        count;
  logic                          empty;
  modport master (
    output evict_valid, evict_addr, evict_data, lookup_addr, wb_reqack, wb_writeack,
    input  evict_ready, lookup_hit, wb_reqcyc, wb_req, wb_reqtag, wb_reqdata, count, empty
  );
  modport slave (
    input  evict_valid, evict_addr, evict_data, lookup_addr, wb_reqack, wb_writeack,
    output evict_ready, lookup_hit, wb_reqcyc, wb_req, wb_reqtag, wb_reqdata, count, empty
  );
endinterface

// File: rtl/dcache_writeback_buffer.sv
// dcache_writeback_buffer: queues evicted dirty lines and replays them in order as request + data beats
module dcache_writeback_buffer #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int LINE_BEATS = 8,
  parameter int DEPTH      = 4,
  parameter logic [TAG_WIDTH-1:0] WRITE_TAG = 13'h100
) (
  input logic clk,
  input logic reset_n,
  dcache_writeback_buffer_if.slave bus
);
  localparam int OFF = $clog2(LINE_BEATS*WIDTH/8);
  localparam int PW  = $clog2(DEPTH);
  localparam int BW  = $clog2(LINE_BEATS);
  localparam int CW  = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DATA = 2'd2, S_WAIT = 2'd3;
  logic [ADDR_WIDTH-1:0]       r_addr [DEPTH];
  logic [WIDTH*LINE_BEATS-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]            r_valid;
  logic [PW-1:0]               r_head, r_tail;
  logic [CW-1:0]               r_count;
  logic [1:0]                  r_state;
  logic [BW-1:0]               r_beat;
  logic                        w_push, w_pop, w_active, w_hit;
  logic [ADDR_WIDTH-1:0]       w_lookup_line;
  assign w_push        = bus.evict_valid && bus.evict_ready;
  assign w_pop         = r_state == S_WAIT && bus.wb_writeack;
  assign w_active      = r_state == S_REQ || r_state == S_DATA;
  assign w_lookup_line = bus.lookup_addr & LINE_MASK;
  assign bus.evict_ready = r_count != CW'(DEPTH);
  assign bus.empty       = r_count == '0;
  assign bus.count       = r_count;
  assign bus.lookup_hit  = w_hit;
  assign bus.wb_reqcyc   = r_state == S_REQ;
  assign bus.wb_reqtag   = w_active ? WRITE_TAG : '0;
  assign bus.wb_req      = r_state != S_IDLE ? r_addr[r_head] : '0;
  // the head entry stays put until its pop, so beats are read straight out of storage
  assign bus.wb_reqdata  = w_active ? r_data[r_head][r_beat*WIDTH +: WIDTH] : '0;
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      w_hit = w_hit | (r_valid[i] && r_addr[i] == w_lookup_line);
  end
  always_ff @(posedge clk)
    if (w_push) begin
      r_addr[r_tail] <= bus.evict_addr & LINE_MASK;
      r_data[r_tail] <= bus.evict_data;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_beat  <= '0;
    end else begin
      if (w_pop) r_valid[r_head] <= 1'b0;
      if (w_push) r_valid[r_tail] <= 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_push) r_tail <= r_tail + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      case (r_state)
        S_IDLE: if (r_count != '0) begin
          r_state <= S_REQ;
          r_beat  <= '0;
        end
        S_REQ: if (bus.wb_reqack) begin
          r_state <= S_DATA;
          r_beat  <= BW'(1);
        end
        S_DATA: if (r_beat == BW'(LINE_BEATS-1)) begin
          r_state <= S_WAIT;
          r_beat  <= '0;
        end else r_beat <= r_beat + 1'b1;
        default: if (bus.wb_writeack) r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// tb_dcache_writeback_buffer: vector table, directed corner sequences and a randomized queue-model run
module tb_dcache_writeback_buffer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  dcache_writeback_buffer_if bus ();
  dcache_writeback_buffer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct { logic [63:0] addr; logic [511:0] data; } line_t;
  typedef struct { logic [63:0] la; logic hit; } lk_t;
  localparam logic [63:0] MASK   = ~64'h3f;
  localparam logic [63:0] NOADDR = 64'hdead_0000;
  lk_t   tbl [9];
  line_t lines [9];
  line_t l;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [511:0] mkline(input logic [7:0] b);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = 64'(b) + 64'(k);
    return r;
  endfunction

  task automatic quiet();
    bus.evict_valid = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_data  = '0;
    bus.lookup_addr = NOADDR;
    bus.wb_reqack   = 1'b0;
    bus.wb_writeack = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [63:0] a, input logic [511:0] d);
    bus.evict_valid = 1'b1;
    bus.evict_addr  = a;
    bus.evict_data  = d;
    tick();
    bus.evict_valid = 1'b0;
  endtask

  task automatic xfer_to_wait(input line_t ln, input int cnt, input logic hit);
    int n = 0;
    while (bus.wb_reqcyc !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("reqcyc_timeout", 64'(n < 20), 64'd1);
    for (int h = 0; h < 2; h++) begin
      chk("wb_req", bus.wb_req, ln.addr);
      chk("wb_reqtag", 64'(bus.wb_reqtag), 64'h100);
      chk("beat0", bus.wb_reqdata, ln.data[63:0]);
      chk("count_req", 64'(bus.count), 64'(cnt));
      if (h == 0) tick();
    end
    bus.wb_reqack = 1'b1;
    tick();
    bus.wb_reqack = 1'b0;
    for (int b = 1; b < 8; b++) begin
      chk("beat", bus.wb_reqdata, ln.data[b*64 +: 64]);
      chk("tag_data", 64'(bus.wb_reqtag), 64'h100);
      chk("cyc_data", 64'(bus.wb_reqcyc), 64'd0);
      chk("hit_data", 64'(bus.lookup_hit), 64'(hit));
      tick();
    end
    chk("data_wait", bus.wb_reqdata, 64'd0);
    chk("tag_wait", 64'(bus.wb_reqtag), 64'd0);
    chk("count_wait", 64'(bus.count), 64'(cnt));
    chk("hit_wait", 64'(bus.lookup_hit), 64'(hit));
  endtask

  task automatic pop_line(input int cnt_after);
    bus.wb_writeack = 1'b1;
    tick();
    bus.wb_writeack = 1'b0;
    chk("count_pop", 64'(bus.count), 64'(cnt_after));
  endtask

  task automatic rand_test();
    line_t q[$];
    line_t nl;
    logic [63:0] base [4];
    int ph, bt;
    logic hm, do_push, do_pop;
    base = '{64'h1000, 64'h1040, 64'h2000, 64'hffff_ffff_ffff_ffc0};
    ph = 0;
    bt = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      nl.addr = base[$urandom_range(0, 3)] | 64'($urandom_range(0, 63));
      for (int k = 0; k < 16; k++) nl.data[k*32 +: 32] = $urandom();
      bus.evict_valid = $urandom_range(0, 7) < (c < 400 ? 5 : 1);
      bus.evict_addr  = nl.addr;
      bus.evict_data  = nl.data;
      bus.lookup_addr = ($urandom_range(0, 4) == 0) ? 64'h5000 : base[$urandom_range(0, 3)] | 64'($urandom_range(0, 63));
      bus.wb_reqack   = 1'($urandom_range(0, 1));
      bus.wb_writeack = 1'($urandom_range(0, 1));
      #1;
      hm = 1'b0;
      foreach (q[i]) if (q[i].addr == (bus.lookup_addr & MASK)) hm = 1'b1;
      chk("r_hit", 64'(bus.lookup_hit), 64'(hm));
      chk("r_count", 64'(bus.count), 64'(q.size()));
      chk("r_ready", 64'(bus.evict_ready), 64'(q.size() != 4));
      chk("r_cyc", 64'(bus.wb_reqcyc), 64'(ph == 1));
      chk("r_tag", 64'(bus.wb_reqtag), (ph == 1 || ph == 2) ? 64'h100 : 64'h0);
      if (ph == 1 || ph == 2) begin
        chk("r_addr", bus.wb_req, q[0].addr);
        chk("r_data", bus.wb_reqdata, q[0].data[bt*64 +: 64]);
      end else chk("r_data_idle", bus.wb_reqdata, 64'd0);
      do_pop  = ph == 3 && bus.wb_writeack;
      do_push = bus.evict_valid && q.size() != 4;
      case (ph)
        0: if (q.size() != 0) begin ph = 1; bt = 0; end
        1: if (bus.wb_reqack) begin ph = 2; bt = 1; end
        2: if (bt == 7) ph = 3; else bt++;
        default: if (do_pop) ph = 0;
      endcase
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{addr: nl.addr & MASK, data: nl.data});
    end
    quiet();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{64'h1040, 1'b1};
    tbl[1] = '{64'h107f, 1'b1};
    tbl[2] = '{64'h1000, 1'b0};
    tbl[3] = '{64'h1080, 1'b0};
    tbl[4] = '{64'h2038, 1'b1};
    tbl[5] = '{64'h2040, 1'b0};
    tbl[6] = '{64'h7fff, 1'b1};
    tbl[7] = '{64'h8000, 1'b0};
    tbl[8] = '{64'h0000, 1'b0};
    for (int i = 0; i < 9; i++) lines[i] = '{64'h4000 + 64'(i) * 64'h40, mkline(8'(i * 8))};

    // reset then idle; stray acks must be ignored
    do_reset();
    chk("rst_ready", 64'(bus.evict_ready), 64'd1);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_cyc", 64'(bus.wb_reqcyc), 64'd0);
    chk("rst_tag", 64'(bus.wb_reqtag), 64'd0);
    chk("rst_req", bus.wb_req, 64'd0);
    chk("rst_data", bus.wb_reqdata, 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.lookup_addr = tbl[i*3].la;
      #1;
      chk("rst_hit", 64'(bus.lookup_hit), 64'd0);
    end
    bus.wb_reqack = 1'b1;
    bus.wb_writeack = 1'b1;
    tick();
    quiet();
    chk("stray_ack_count", 64'(bus.count), 64'd0);
    chk("stray_ack_cyc", 64'(bus.wb_reqcyc), 64'd0);

    // table-driven snoop vectors against three queued lines
    push(64'h1040, mkline(8'h10));
    push(64'h2000, mkline(8'h20));
    push(64'h7fc0, mkline(8'h70));
    chk("tbl_count", 64'(bus.count), 64'd3);
    for (int i = 0; i < 9; i++) begin
      bus.lookup_addr = tbl[i].la;
      #1;
      chk($sformatf("tbl_hit[%0d]", i), 64'(bus.lookup_hit), 64'(tbl[i].hit));
    end

    // single line with delayed writeack
    do_reset();
    l = '{64'h1040, mkline(8'hA0)};
    push(l.addr, l.data);
    chk("single_count", 64'(bus.count), 64'd1);
    xfer_to_wait(l, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_count", 64'(bus.count), 64'd1);
    end
    pop_line(0);
    chk("single_empty", 64'(bus.empty), 64'd1);

    // fill to DEPTH with reqack low, fifth offer refused, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) push(lines[i].addr, lines[i].data);
    chk("full_ready", 64'(bus.evict_ready), 64'd0);
    bus.evict_valid = 1'b1;
    bus.evict_addr  = 64'h9000;
    bus.evict_data  = mkline(8'h90);
    tick();
    bus.evict_valid = 1'b0;
    chk("full_count", 64'(bus.count), 64'd4);
    xfer_to_wait(lines[0], 4, 1'b0);
    chk("full_ready_wait", 64'(bus.evict_ready), 64'd0);
    pop_line(3);
    chk("ready_after_pop", 64'(bus.evict_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      xfer_to_wait(lines[i], 4 - i, 1'b0);
      pop_line(3 - i);
    end
    tick();
    tick();
    chk("drained_cyc", 64'(bus.wb_reqcyc), 64'd0);

    // snoop hit lasts through the writeack cycle and clears after it
    do_reset();
    l = '{64'h2000, mkline(8'h50)};
    bus.lookup_addr = 64'h2038;
    bus.evict_valid = 1'b1;
    bus.evict_addr  = l.addr;
    bus.evict_data  = l.data;
    #1;
    chk("hit_same_cycle", 64'(bus.lookup_hit), 64'd0);
    tick();
    bus.evict_valid = 1'b0;
    chk("hit_next_cycle", 64'(bus.lookup_hit), 64'd1);
    xfer_to_wait(l, 1, 1'b1);
    bus.wb_writeack = 1'b1;
    #1;
    chk("hit_ack_cycle", 64'(bus.lookup_hit), 64'd1);
    tick();
    bus.wb_writeack = 1'b0;
    chk("hit_after_ack", 64'(bus.lookup_hit), 64'd0);
    bus.lookup_addr = 64'h2040;
    push(l.addr, l.data);
    chk("miss_next_line", 64'(bus.lookup_hit), 64'd0);
    xfer_to_wait(l, 1, 1'b0);
    pop_line(0);

    // push concurrent with pop at count 2 across nine lines
    do_reset();
    push(lines[0].addr, lines[0].data);
    push(lines[1].addr, lines[1].data);
    for (int i = 2; i < 9; i++) begin
      xfer_to_wait(lines[i-2], 2, 1'b0);
      bus.wb_writeack = 1'b1;
      bus.evict_valid = 1'b1;
      bus.evict_addr  = lines[i].addr;
      bus.evict_data  = lines[i].data;
      #1;
      chk("pp_ready", 64'(bus.evict_ready), 64'd1);
      tick();
      bus.wb_writeack = 1'b0;
      bus.evict_valid = 1'b0;
      chk("pp_count", 64'(bus.count), 64'd2);
    end
    xfer_to_wait(lines[7], 2, 1'b0);
    pop_line(1);
    xfer_to_wait(lines[8], 1, 1'b0);
    pop_line(0);

    // asynchronous reset in the middle of data beat 3
    do_reset();
    l = '{64'h3000, mkline(8'h30)};
    bus.lookup_addr = 64'h3000;
    push(l.addr, l.data);
    tick();
    chk("mid_cyc", 64'(bus.wb_reqcyc), 64'd1);
    bus.wb_reqack = 1'b1;
    tick();
    bus.wb_reqack = 1'b0;
    tick();
    tick();
    chk("mid_beat3", bus.wb_reqdata, l.data[3*64 +: 64]);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_data", bus.wb_reqdata, 64'd0);
    chk("arst_tag", 64'(bus.wb_reqtag), 64'd0);
    chk("arst_req", bus.wb_req, 64'd0);
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_empty", 64'(bus.empty), 64'd1);
    chk("arst_ready", 64'(bus.evict_ready), 64'd1);
    chk("arst_hit", 64'(bus.lookup_hit), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_count", 64'(bus.count), 64'd0);
    chk("post_rst_cyc", 64'(bus.wb_reqcyc), 64'd0);
    chk("post_rst_hit", 64'(bus.lookup_hit), 64'd0);

    rand_test();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
